// File: rtl/decode_queue_if.sv
// Fetch-side and decode-side signal bundle for the decode queue.
interface decode_queue_if #(
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic [7:0]               in_pc;
  logic [7:0]               in_instr;
  logic                     in_ready;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [7:0]               out_pc;
  logic [3:0]               out_op;
  logic [1:0]               out_rd;
  logic [1:0]               out_rs;
  logic                     out_is_alu;
  logic                     out_is_mem;
  logic                     out_is_branch;
  logic                     out_writes_rd;
  logic                     out_illegal;
  logic                     halted;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_op, out_rd, out_rs,
           out_is_alu, out_is_mem, out_is_branch, out_writes_rd,
           out_illegal, halted, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_op, out_rd, out_rs,
           out_is_alu, out_is_mem, out_is_branch, out_writes_rd,
           out_illegal, halted, count
  );
endinterface

// File: rtl/decode_queue.sv
// Circular instruction queue between fetch and decode. Stores {pc, instr}
// pairs and decodes the head entry combinationally. Popping a HALT stops
// the queue until a flush.
module decode_queue #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  decode_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN, HALTED} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [15:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        head;
  logic               halted;
  logic               in_rdy;
  logic               out_vld;
  logic               push;
  logic               pop;
  logic               halt_pop;

  assign head     = mem[rd_ptr];
  assign halted   = (state == HALTED);
  assign in_rdy   = (cnt != CNT_W'(DEPTH)) && !halted;
  assign out_vld  = (cnt != '0) && !halted;
  assign pop      = out_vld && bus.out_ready && !bus.flush;
  assign halt_pop = pop && (head[7:4] == 4'hF);
  // A push that coincides with popping HALT is dropped along with the queue.
  assign push     = bus.in_valid && in_rdy && !bus.flush && !halt_pop;

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.halted    = halted;
  assign bus.count     = cnt;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // FSM next state: flush always returns to RUN, popping HALT stops the queue.
  always_comb begin
    state_nxt = state;
    if (bus.flush)                      state_nxt = RUN;
    else if (state == RUN && halt_pop)  state_nxt = HALTED;
  end

  // Pointer and occupancy update; flush and HALT both empty the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush || halt_pop) begin
      rd_ptr <= wr_ptr;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage, left unreset since it is never visible while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_pc, bus.in_instr};
  end

  // Head-entry decode, zeroed whenever no valid entry is presented.
  always_comb begin
    bus.out_pc        = '0;
    bus.out_op        = '0;
    bus.out_rd        = '0;
    bus.out_rs        = '0;
    bus.out_is_alu    = 1'b0;
    bus.out_is_mem    = 1'b0;
    bus.out_is_branch = 1'b0;
    bus.out_writes_rd = 1'b0;
    bus.out_illegal   = 1'b0;
    if (out_vld) begin
      bus.out_pc = head[15:8];
      bus.out_op = head[7:4];
      bus.out_rd = head[3:2];
      bus.out_rs = head[1:0];
      case (head[7:4])
        4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
          bus.out_is_alu    = 1'b1;
          bus.out_writes_rd = 1'b1;
        end
        4'h6: begin
          bus.out_is_mem    = 1'b1;
          bus.out_writes_rd = 1'b1;
        end
        4'h7:                                 bus.out_is_mem    = 1'b1;
        4'h8:                                 bus.out_is_branch = 1'b1;
        4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE:   bus.out_illegal   = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
